product_display: RTL and testbench
==================================

// Module: product_display
// PURPOSE
//  Downstream consumer of boothMult. Captures the signed product when the multiplier signals
//  Finish, converts it to sign plus decimal magnitude with a sequential shift-add-3
//  (double-dabble) engine, and drives six active-low seven-segment digits on the DE10-Lite.
//  Display holds the last result until a new conversion completes.
// PARAMETERS
//  WIDTH     16  product width in bits (two's complement); DIGITS must cover 2^(WIDTH-1)
//  DIGITS     5  decimal magnitude digits (HEX0..HEX4); HEX5 is the sign digit
// PORTS
//  clk      in   1      system clock; all state changes on posedge clk
//  Resetn   in   1      synchronous reset, active-high (asserted = 1)
//  Finish   in   1      boothMult done flag; level, held high while the result is valid
//  FProduct in   WIDTH  signed product from boothMult
//  Busy     out  1      1 while a conversion is in progress
//  Valid    out  1      1 once at least one conversion has completed since reset
//  HEX0..4  out  7 ea   decimal digits, units in HEX0; {g,f,e,d,c,b,a}, active-low
//  HEX5     out  7      sign digit: '-' (7'b0111111) if negative, else blank (7'h7F)
// BEHAVIOUR
//  Reset (Resetn=1 at posedge): state IDLE, Busy=0, Valid=0, HEX0..HEX5=7'h7F, cnt=0,
//   bcd=0, fin_d=1. fin_d resets to 1 so a Finish already high is not a new event.
//   Reset mid-conversion aborts it. The display returns to blank.
//  Trigger: start = Finish & ~fin_d, a rising edge. fin_d <= Finish every cycle.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE
//   IDLE : on start at edge N, latch sign=FProduct[WIDTH-1].
//          mag = sign ? -FProduct : FProduct, as an unsigned WIDTH-bit value, so 16'h8000 -> 32768.
//          Set bcd=0, cnt=WIDTH, go SHIFT.
//   SHIFT: per cycle, add 3 to every BCD nibble >= 5, then shift {bcd,mag} left by 1.
//          cnt decrements; after the WIDTH-th shift (edge N+WIDTH), go DONE.
//   DONE : edge N+WIDTH+1 registers all HEX outputs from bcd/sign, sets Valid=1, goes IDLE.
//  Latency: start edge to new HEX outputs is WIDTH+1 cycles (17 at default).
//   Busy=1 from edge N through edge N+WIDTH+1, i.e. in SHIFT and DONE.
//  A Finish rising edge while Busy is ignored and not queued. fin_d still tracks it.
//  Leading-zero blanking: a digit above the most significant nonzero digit shows 7'h7F.
//   HEX0 always shows a digit, so 0 displays as '0'. Minus is always in HEX5.
//  Negative zero cannot occur: sign comes from FProduct, and FProduct=0 gives a blank HEX5.
//  HEX outputs change only in DONE, so there is no partial-result flicker.
//  Segment codes 0-9: 1000000 1111001 0100100 0110000 0011001 0010010 0000010 1111000 0000000 0010000
// STRUCTURE
//  Package mult_disp_pkg:
//   state encoding (IDLE/SHIFT/DONE), SEG_BLANK=7'h7F, SEG_MINUS=7'b0111111, digit table.
//  Sub-module bcd_to_seg7: 4-bit BCD plus blank flag in, 7-bit active-low code out, combinational.
//   Instantiated DIGITS times.
//  Top holds the FSM, the edge detector, the shift-add-3 datapath and the output registers.
// TESTING
//  1 Reset, FProduct=0, Finish 0->1 -> 17 cycles later Valid=1, HEX0=1000000, HEX1..5=7F.
//  2 FProduct=16'sd16129 (127*127) -> HEX4..0 = 1,6,1,2,9; HEX5=7F; Busy high 17 cycles.
//  3 FProduct=-16'sd16256 (127*-128) -> HEX5=0111111; HEX4..0 = 1,6,2,5,6.
//  4 FProduct=16'h8000 -> '-',3,2,7,6,8. Then FProduct=7 -> HEX0='7' (1111000), HEX1..5=7F.
//  5 Finish held high for 40 cycles, plus a second rise at cycle 5 of Busy
//     -> exactly one conversion; HEX unchanged until its DONE.
//  6 Resetn=1 at shift cycle 8 with Finish still high
//     -> Busy=0, Valid=0, all HEX=7F; no retrigger until Finish falls and rises again.

Source files
------------

// File: rtl/product_display_pkg.sv
// Shared types and segment encodings for the boothMult product display path.
package mult_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} codes for decimal digits; non-decimal input blanks.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-low seven-segment code, with forced blanking.
module bcd_to_seg7
  import mult_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg_code(bcd);

endmodule

// File: rtl/product_display.sv
// Captures a signed boothMult product on Finish rising, converts it to sign plus
// decimal magnitude by shift-add-3, and drives six active-low seven-segment digits.
module product_display
  import mult_disp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             Resetn,
  input  logic             Finish,
  input  logic [WIDTH-1:0] FProduct,
  output logic             Busy,
  output logic             Valid,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e                  state_q, state_d;
  logic                    fin_q;
  logic                    sign_q, sign_d;
  logic [WIDTH-1:0]        mag_q, mag_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [DIGITS:0][6:0]    hex_q, hex_d;
  logic [DIGITS-1:0][6:0]  seg_w;
  logic [DIGITS-1:0]       blank_w;
  logic                    start;

  // fin_q resets high so a Finish already asserted out of reset is not an edge.
  assign start = Finish & ~fin_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking: a digit blanks when it and everything above it is zero.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_units
      assign blank_w[i] = 1'b0;
    end else begin : g_upper
      assign blank_w[i] = (bcd_q[BCD_W-1:4*i] == '0);
    end
    bcd_to_seg7 u_seg (
      .bcd   (bcd_q[4*i +: 4]),
      .blank (blank_w[i]),
      .seg   (seg_w[i])
    );
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    hex_d   = hex_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d  = FProduct[WIDTH-1];
          mag_d   = FProduct[WIDTH-1] ? (~FProduct + 1'b1) : FProduct;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        for (int i = 0; i < DIGITS; i++)
          hex_d[i] = seg_w[i];
        hex_d[DIGITS] = sign_q ? SEG_MINUS : SEG_BLANK;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Resetn) begin
      state_q <= ST_IDLE;
      fin_q   <= 1'b1;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hex_q   <= {(DIGITS+1){SEG_BLANK}};
    end else begin
      state_q <= state_d;
      fin_q   <= Finish;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hex_q   <= hex_d;
    end
  end

  assign Busy  = (state_q != ST_IDLE);
  assign Valid = valid_q;
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign HEX4  = hex_q[4];
  assign HEX5  = hex_q[DIGITS];

endmodule

// File: tb/tb_product_display.sv
// Self-checking bench for product_display against a decimal-arithmetic display model.
module tb_product_display;

  logic        clk = 1'b0;
  logic        Resetn;
  logic        Finish;
  logic [15:0] FProduct;
  logic        Busy, Valid;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int checks = 0;
  int errors = 0;

  product_display #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .Resetn(Resetn), .Finish(Finish), .FProduct(FProduct),
    .Busy(Busy), .Valid(Valid),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected {HEX5..HEX0} for a signed 16-bit product, from decimal arithmetic.
  function automatic logic [41:0] model(input logic [15:0] p);
    int v, m, pw;
    logic [41:0] r;
    v  = int'($signed(p));
    m  = (v < 0) ? -v : v;
    pw = 1;
    for (int i = 0; i < 5; i++) begin
      r[7*i +: 7] = (i > 0 && m < pw) ? 7'h7F : seg((m / pw) % 10);
      pw = pw * 10;
    end
    r[41:35] = (v < 0) ? 7'b0111111 : 7'h7F;
    return r;
  endfunction

  function automatic logic [41:0] hex_all();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise Finish with product p; check latency, busy window, hold-off of HEX, final display.
  task automatic convert(input logic [15:0] p, input string tag);
    logic [41:0] prev;
    int bc;
    prev     = hex_all();
    FProduct = p;
    Finish   = 1'b1;
    tick();
    bc = 0;
    while (Busy && bc < 40) begin
      bc++;
      if (hex_all() !== prev) chk({tag, "_noflicker"}, 64'(hex_all()), 64'(prev));
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(bc), 64'd17);
    chk({tag, "_valid"}, 64'(Valid), 64'd1);
    chk({tag, "_hex"}, 64'(hex_all()), 64'(model(p)));
    Finish = 1'b0;
    tick();
  endtask

  initial begin
    logic [41:0] prev;
    int bc;
    logic [15:0] r;

    Resetn = 1'b1; Finish = 1'b0; FProduct = '0;
    tick(); tick();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_valid", 64'(Valid), 64'd0);
    chk("rst_hex", 64'(hex_all()), {22'd0, {6{7'h7F}}});
    Resetn = 1'b0;
    tick();

    // Directed cases
    convert(16'd0, "zero");
    chk("zero_literal", 64'(hex_all()), {22'd0, {5{7'h7F}}, 7'b1000000});
    convert(16'd16129, "p16129");
    convert(16'hC080, "n16256");
    chk("n16256_literal", 64'(hex_all()),
        {22'd0, 7'b0111111, 7'b1111001, 7'b0000010, 7'b0100100, 7'b0010010, 7'b0000010});
    convert(16'h8000, "n32768");
    convert(16'd7, "p7");
    chk("p7_literal", 64'(hex_all()), {22'd0, {5{7'h7F}}, 7'b1111000});
    convert(16'h7FFF, "p32767");
    convert(16'hFFFF, "n1");
    convert(16'd10, "p10");

    // Finish held high with a second rise during Busy: one conversion only
    prev = hex_all();
    FProduct = 16'd4321; Finish = 1'b1;
    tick();
    bc = 0;
    while (Busy && bc < 40) begin
      bc++;
      if (bc == 4) Finish = 1'b0;
      if (bc == 5) Finish = 1'b1;
      if (hex_all() !== prev) chk("hold_noflicker", 64'(hex_all()), 64'(prev));
      tick();
    end
    chk("hold_busy_cycles", 64'(bc), 64'd17);
    chk("hold_hex", 64'(hex_all()), 64'(model(16'd4321)));
    FProduct = 16'd99;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (Busy) bc++;
      tick();
    end
    chk("hold_no_retrigger", 64'(bc), 64'd0);
    chk("hold_hex_kept", 64'(hex_all()), 64'(model(16'd4321)));
    Finish = 1'b0;
    tick();

    // Reset in the middle of shifting with Finish still high
    FProduct = 16'd555; Finish = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("midrst_busy_before", 64'(Busy), 64'd1);
    Resetn = 1'b1;
    tick();
    Resetn = 1'b0;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_valid", 64'(Valid), 64'd0);
    chk("midrst_hex", 64'(hex_all()), {22'd0, {6{7'h7F}}});
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      if (Busy) bc++;
      tick();
    end
    chk("midrst_no_retrigger", 64'(bc), 64'd0);
    Finish = 1'b0;
    tick();
    convert(16'd555, "after_rst");

    // Randomized products against the decimal model
    for (int k = 0; k < 16; k++) begin
      r = 16'($urandom);
      convert(r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
